// File: rtl/multi_debounce_evt.sv
// N-channel debouncer: two-flop synchroniser, saturating hysteretic integrator,
// registered edge pulses, long-press detection and sticky event flags.
module multi_debounce_evt #(
   parameter int               NUMCH      = 3,
   parameter int               NUMCYCLES  = 500_000,
   parameter int               LONGCYCLES = 50_000_000,
   parameter logic [NUMCH-1:0] INIT_LEVEL = {NUMCH{1'b0}}
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NUMCH-1:0] i_in,
   input  logic [NUMCH-1:0] i_clr,
   output logic [NUMCH-1:0] o_level,
   output logic [NUMCH-1:0] o_rise,
   output logic [NUMCH-1:0] o_fall,
   output logic [NUMCH-1:0] o_long,
   output logic [NUMCH-1:0] o_held,
   output logic [NUMCH-1:0] o_evt
);

   localparam int CW = $clog2(NUMCYCLES + 1);
   localparam int HW = $clog2(LONGCYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(NUMCYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONGCYCLES);

   for (genvar ch = 0; ch < NUMCH; ch++) begin : g_ch
      logic          s1, s2;
      logic [CW-1:0] cnt, cnt_nxt;
      logic [HW-1:0] hold, hold_nxt;
      logic          level, level_nxt;
      logic          rise, fall;
      logic          lng, lng_nxt;
      logic          held, held_nxt;
      logic          evt, evt_nxt;

      always_comb begin
         cnt_nxt   = cnt;
         level_nxt = level;
         hold_nxt  = hold;
         lng_nxt   = 1'b0;
         held_nxt  = 1'b0;
         evt_nxt   = 1'b0;

         if (s2 && (cnt != CNT_MAX))
            cnt_nxt = cnt + 1'b1;
         else if (!s2 && (cnt != '0))
            cnt_nxt = cnt - 1'b1;

         // Level only moves at the integrator rails: full-range hysteresis.
         if (cnt_nxt == CNT_MAX)
            level_nxt = 1'b1;
         else if (cnt_nxt == '0)
            level_nxt = 1'b0;

         if (!level)
            hold_nxt = '0;
         else if (hold != HOLD_MAX)
            hold_nxt = hold + 1'b1;

         lng_nxt  = level && (hold != HOLD_MAX) && (hold_nxt == HOLD_MAX);
         held_nxt = level_nxt && (held || lng_nxt);
         evt_nxt  = (evt && !i_clr[ch]) || rise || lng;
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            s1    <= INIT_LEVEL[ch];
            s2    <= INIT_LEVEL[ch];
            cnt   <= INIT_LEVEL[ch] ? CNT_MAX : '0;
            level <= INIT_LEVEL[ch];
            rise  <= 1'b0;
            fall  <= 1'b0;
            hold  <= '0;
            lng   <= 1'b0;
            held  <= 1'b0;
            evt   <= 1'b0;
         end else begin
            s1    <= i_in[ch];
            s2    <= s1;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= level_nxt && !level;
            fall  <= !level_nxt && level;
            hold  <= hold_nxt;
            lng   <= lng_nxt;
            held  <= held_nxt;
            evt   <= evt_nxt;
         end
      end

      assign o_level[ch] = level;
      assign o_rise[ch]  = rise;
      assign o_fall[ch]  = fall;
      assign o_long[ch]  = lng;
      assign o_held[ch]  = held;
      assign o_evt[ch]   = evt;
   end

endmodule

// File: doc/multi_debounce_evt.md
Name: multi_debounce_evt

Overview:
- Parametrised N-channel debouncer for push-buttons and switches; the next generation of the single-bit integrator debouncer.
- Adds per-channel input synchronisation, a hysteretic saturating integrator, registered rise/fall pulses, long-press detection and sticky event flags with a clear mask.
- Sits between board pins and the PicoRV GPIO/IRQ peripheral. Firmware polls or clears the flags.

Parameters:
- NUMCH, 3, number of independent channels (>=1).
- NUMCYCLES, 500_000, consecutive-majority clock count needed to change debounced level (>=1).
- LONGCYCLES, 50_000_000, clock cycles o_level must stay high before o_long fires (>=1).
- INIT_LEVEL, {NUMCH{1'b0}}, per-channel debounced level (and sync flop value) after reset.

Ports:
- i_clk    in   1      system clock
- i_rst    in   1      asynchronous, active-high reset
- i_in     in   NUMCH  raw, asynchronous pin inputs
- i_clr    in   NUMCH  per-channel clear of o_evt, one-cycle strobe
- o_level  out  NUMCH  debounced level
- o_rise   out  NUMCH  one-cycle pulse on debounced 0->1
- o_fall   out  NUMCH  one-cycle pulse on debounced 1->0
- o_long   out  NUMCH  one-cycle pulse when high time reaches LONGCYCLES
- o_held   out  NUMCH  level, high from o_long until o_level falls
- o_evt    out  NUMCH  sticky flag, set by o_rise or o_long, cleared by i_clr

Behaviour:
- Reset (async assert, sync release):
  - sync flops s1/s2 = INIT_LEVEL[ch].
  - cnt = NUMCYCLES if INIT_LEVEL[ch] else 0.
  - o_level = INIT_LEVEL.
  - o_rise, o_fall, o_long, o_held, o_evt = 0.
  - hold counter = 0.
  - Reset mid-count discards all progress; no pulses are generated by reset assert or release.
- Synchroniser:
  - Two flops per channel. Only s2 feeds the logic.
- Integrator (per channel):
  - cnt width = $clog2(NUMCYCLES+1).
  - s2=1 and cnt<NUMCYCLES: cnt+1. s2=0 and cnt>0: cnt-1. Otherwise hold (saturating, never wraps).
- Level hysteresis:
  - o_level <= 1 on the edge where cnt becomes NUMCYCLES.
  - o_level <= 0 on the edge where cnt becomes 0.
  - Between the two limits o_level holds. This is full-range hysteresis, not midpoint.
- Latency:
  - From cnt=0 with i_in held high, sampled from edge k, o_level is high after edge k+NUMCYCLES+1. That is 2 sync edges then NUMCYCLES-1 further increments, with o_level registered on the saturating edge.
  - Falling latency is symmetric.
  - NUMCYCLES=1 degenerates to sync-only plus one register.
- Edge pulses:
  - o_rise/o_fall are registered and high exactly for the first cycle o_level shows its new value. Never both high at once.
- Long press:
  - Hold counter width = $clog2(LONGCYCLES+1).
  - Increments each cycle o_level=1, saturates at LONGCYCLES, and is cleared to 0 on the cycle o_level=0.
  - o_long pulses one cycle on the edge where the counter reaches LONGCYCLES; o_held is set on the same edge.
  - o_long fires at most once per press.
  - o_held clears together with o_level falling. o_fall still pulses after a long press.
- Sticky events:
  - o_evt[ch] <= (o_evt[ch] & ~i_clr[ch]) | o_rise[ch] | o_long[ch].
  - Simultaneous set and clear: set wins.
  - i_clr on a channel with no event has no effect.
- Independence:
  - Channels share only clock/reset. Activity on one channel never affects another's counters or outputs.

Test Plan (NUMCH=3, NUMCYCLES=4, LONGCYCLES=10, INIT_LEVEL=3'b000):
- Reset: assert i_rst mid-count with i_in=3'b111 -> all outputs 0 immediately (async). After release, o_level[0] rises only after a full 2+4-edge interval. No pulse at release.
- Clean press: i_in[0] 0->1 held -> o_level[0]=1 and o_rise[0]=1 for exactly 1 cycle, 5 edges after first sample high, then o_evt[0]=1 and stays. Channels 1,2 stay 0.
- Bounce: i_in[1] toggles 1,1,0,1,1,0,1,1,... (net +1 per 3 cycles) -> o_level[1] reaches 1 only once cnt hits 4. A subsequent 1-cycle glitch low does not drop o_level (cnt 4->3 and back).
- Long press: hold i_in[2]=1 -> o_long[2] pulses once, 10 cycles after o_level[2] rose, and o_held[2]=1. Keep holding 30 more cycles -> no further o_long. Release -> o_fall[2] pulse with o_held[2] cleared the same edge.
- Clear handshake: o_evt[0]=1, pulse i_clr[0] -> o_evt[0]=0 next cycle. Pulse i_clr[0] on the same cycle as a new o_rise[0] -> o_evt[0] remains 1.
- INIT_LEVEL=3'b111 build, i_in=3'b111 through reset -> o_level=3'b111 from reset, no o_rise after release. Drive 0 -> o_fall after 5 edges.
